// File: rtl/prio_encoder_8to3_if.sv
// Request/code channel of the sequential priority encoder.
// master = encoder side, slave = request source plus code consumer.
interface prio_encoder_8to3_if #(
  parameter int W_CODE = 3
);
  localparam int N_REQ = 1 << W_CODE;

  logic [N_REQ-1:0]  req_in;
  logic [W_CODE-1:0] out_code;
  logic              out_vld;
  logic              out_rdy;
  logic              out_multi;
  logic              pend_any;

  modport master (
    input  req_in,
    input  out_rdy,
    output out_code,
    output out_vld,
    output out_multi,
    output pend_any
  );

  modport slave (
    output req_in,
    output out_rdy,
    input  out_code,
    input  out_vld,
    input  out_multi,
    input  pend_any
  );
endinterface

// File: rtl/prio_encoder_8to3.sv
// Sequential 8-to-3 priority encoder: latches request lines and serves them one code per transfer.
// Define ROUND_ROBIN_EN for rotating priority; otherwise the highest pending index always wins.
module prio_encoder_8to3 #(
  parameter int W_CODE = 3
) (
  input  logic                       clk,
  input  logic                       rst_n,
  prio_encoder_8to3_if.master        bus
);
  localparam int N_REQ = 1 << W_CODE;

  logic [N_REQ-1:0]  pend_q, pend_d;
  logic [W_CODE-1:0] code_q, code_d;
  logic              vld_q, vld_d;
  logic              multi_q, multi_d;

  logic [W_CODE-1:0] sel;
  logic [N_REQ-1:0]  sel_oh;
  logic [N_REQ-1:0]  clr_mask;
  logic              slot_free;
  logic              load;

`ifdef ROUND_ROBIN_EN
  logic [W_CODE-1:0] ptr_q, ptr_d;
  logic [W_CODE-1:0] idx;
  logic              found;

  // Scan downward from ptr-1; the last step (k == N_REQ) revisits ptr itself.
  always_comb begin
    sel   = '0;
    idx   = '0;
    found = 1'b0;
    for (int k = 1; k <= N_REQ; k++) begin
      idx = ptr_q - W_CODE'(k);
      if (!found && pend_q[idx]) begin
        sel   = idx;
        found = 1'b1;
      end
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (load) ptr_d = sel;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ptr_q <= '0;
    else        ptr_q <= ptr_d;
  end
`else
  always_comb begin
    sel = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (pend_q[i]) sel = W_CODE'(i);
    end
  end
`endif

  always_comb begin
    slot_free = !vld_q || bus.out_rdy;
    load      = slot_free && (|pend_q);
    sel_oh    = N_REQ'(1) << sel;
    clr_mask  = load ? sel_oh : '0;

    // New requests are OR'd in after the clear, so a re-request of the served bit survives.
    pend_d    = (pend_q & ~clr_mask) | bus.req_in;

    code_d    = code_q;
    multi_d   = multi_q;
    vld_d     = vld_q;
    if (slot_free) vld_d = |pend_q;
    if (load) begin
      code_d  = sel;
      multi_d = |(pend_q & ~sel_oh);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_q  <= '0;
      code_q  <= '0;
      vld_q   <= 1'b0;
      multi_q <= 1'b0;
    end else begin
      pend_q  <= pend_d;
      code_q  <= code_d;
      vld_q   <= vld_d;
      multi_q <= multi_d;
    end
  end

  assign bus.out_code  = code_q;
  assign bus.out_vld   = vld_q;
  assign bus.out_multi = multi_q;
  assign bus.pend_any  = |pend_q;
endmodule

// File: tb/tb_prio_encoder_8to3.sv
// Bench for prio_encoder_8to3: single-burst vector table plus stall, reset and re-request sequences.
module tb_prio_encoder_8to3;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  prio_encoder_8to3_if #(.W_CODE(3)) bus ();
  prio_encoder_8to3 #(.W_CODE(3)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  typedef struct packed {
    logic [2:0] code;
    logic       multi;
  } xfer_t;

  typedef struct packed {
    logic [7:0]      req;
    logic [3:0]      n;
    logic [0:7][2:0] codes;
    logic [0:7]      multi;
  } vec_t;

  xfer_t exp_q[$];
  vec_t  tbl[6];
  int    total = 0;
  int    bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic push(input logic [2:0] c, input logic m);
    exp_q.push_back({c, m});
  endtask

  // Every accepted transfer is matched against the head of the scoreboard.
  always @(negedge clk) begin
    xfer_t e;
    if (rst_n && bus.out_vld && bus.out_rdy) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_xfer actual code=%0d multi=%0d required none t=%0t",
                 bus.out_code, bus.out_multi, $time);
      end else begin
        e = exp_q.pop_front();
        check("xfer_code", 32'(bus.out_code), 32'(e.code));
        check("xfer_multi", 32'(bus.out_multi), 32'(e.multi));
      end
    end
  end

  task automatic do_reset();
    @(negedge clk);
    rst_n       = 1'b0;
    bus.req_in  = '0;
    bus.out_rdy = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    exp_q.delete();
    rst_n = 1'b1;
  endtask

  task automatic wait_drain(input string name, input int budget);
    int n = 0;
    while ((exp_q.size() != 0 || bus.out_vld) && n < budget) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (exp_q.size() != 0 || bus.out_vld) begin
      bad++;
      $display("FAIL %s drain actual left=%0d vld=%0d required left=0 vld=0",
               name, exp_q.size(), bus.out_vld);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0] = '{req: 8'h04, n: 4'd1, codes: {3'd2, 21'd0}, multi: 8'b0000_0000};
    tbl[1] = '{req: 8'hA5, n: 4'd4, codes: {3'd7, 3'd5, 3'd2, 3'd0, 12'd0}, multi: 8'b1110_0000};
    tbl[2] = '{req: 8'h80, n: 4'd1, codes: {3'd7, 21'd0}, multi: 8'b0000_0000};
    tbl[3] = '{req: 8'h01, n: 4'd1, codes: {3'd0, 21'd0}, multi: 8'b0000_0000};
    tbl[4] = '{req: 8'hFF, n: 4'd8,
               codes: {3'd7, 3'd6, 3'd5, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0}, multi: 8'b1111_1110};
    tbl[5] = '{req: 8'h3C, n: 4'd4, codes: {3'd5, 3'd4, 3'd3, 3'd2, 12'd0}, multi: 8'b1110_0000};

    bus.req_in  = '0;
    bus.out_rdy = 1'b0;
    do_reset();
    check("rst_vld", 32'(bus.out_vld), 0);
    check("rst_code", 32'(bus.out_code), 0);
    check("rst_multi", 32'(bus.out_multi), 0);
    check("rst_pend_any", 32'(bus.pend_any), 0);

    // Single-cycle bursts: one-cycle latency, then n back-to-back codes, then idle.
    for (int v = 0; v < 6; v++) begin
      do_reset();
      bus.out_rdy = 1'b1;
      for (int i = 0; i < int'(tbl[v].n); i++) push(tbl[v].codes[i], tbl[v].multi[i]);
      bus.req_in = tbl[v].req;
      @(posedge clk);
      #1 bus.req_in = '0;
      @(negedge clk);
      check("lat_vld_early", 32'(bus.out_vld), 0);
      check("lat_pend_any", 32'(bus.pend_any), 1);
      for (int c = 0; c < int'(tbl[v].n); c++) begin
        @(negedge clk);
        check("burst_vld", 32'(bus.out_vld), 1);
      end
      @(negedge clk);
      check("burst_end_vld", 32'(bus.out_vld), 0);
      check("burst_end_pend", 32'(bus.pend_any), 0);
      check("burst_sb_empty", 32'(exp_q.size()), 0);
      @(posedge clk);
      #1;
    end

    // Async reset while stalled with pending requests.
    do_reset();
    bus.req_in = 8'h0F;
    repeat (2) @(posedge clk);
    #1 bus.req_in = '0;
    @(negedge clk);
    check("stall_vld", 32'(bus.out_vld), 1);
    check("stall_code", 32'(bus.out_code), 3);
    @(posedge clk);
    @(negedge clk);
    check("stall_hold_code", 32'(bus.out_code), 3);
    check("stall_pend_any", 32'(bus.pend_any), 1);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_vld", 32'(bus.out_vld), 0);
    check("async_rst_code", 32'(bus.out_code), 0);
    check("async_rst_multi", 32'(bus.out_multi), 0);
    check("async_rst_pend_any", 32'(bus.pend_any), 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_vld", 32'(bus.out_vld), 0);

    // Stall with code 3 valid while 8'h81 arrives.
    do_reset();
    bus.req_in = 8'h08;
    @(posedge clk);
    #1 bus.req_in = '0;
    @(posedge clk);
    #1 bus.req_in = 8'h81;
    @(posedge clk);
    #1 bus.req_in = '0;
    @(negedge clk);
    check("hold_vld", 32'(bus.out_vld), 1);
    check("hold_code", 32'(bus.out_code), 3);
    check("hold_multi", 32'(bus.out_multi), 0);
    @(posedge clk);
    @(negedge clk);
    check("hold_code2", 32'(bus.out_code), 3);
    @(posedge clk);
    #1;
    push(3'd3, 1'b0);
`ifdef ROUND_ROBIN_EN
    push(3'd0, 1'b1);
    push(3'd7, 1'b0);
`else
    push(3'd7, 1'b1);
    push(3'd0, 1'b0);
`endif
    bus.out_rdy = 1'b1;
    wait_drain("stall_seq", 20);

    // Re-request of the bit being loaded keeps it pending.
    do_reset();
    bus.out_rdy = 1'b1;
    push(3'd4, 1'b0);
    push(3'd4, 1'b0);
    bus.req_in = 8'h10;
    repeat (2) @(posedge clk);
    #1 bus.req_in = '0;
    @(negedge clk);
    check("set_wins_pend", 32'(bus.pend_any), 1);
    check("set_wins_code", 32'(bus.out_code), 4);
    wait_drain("set_wins", 20);

    // Two requests held high: rotation vs fixed priority.
    do_reset();
    bus.out_rdy = 1'b1;
`ifdef ROUND_ROBIN_EN
    for (int i = 0; i < 6; i++) push((i % 2 == 0) ? 3'd4 : 3'd0, 1'b1);
    push(3'd4, 1'b0);
`else
    for (int i = 0; i < 6; i++) push(3'd4, 1'b1);
    push(3'd0, 1'b0);
`endif
    bus.req_in = 8'h11;
    repeat (6) @(posedge clk);
    #1 bus.req_in = '0;
    wait_drain("held_pair", 20);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
